branch_resolve_unit: RTL and testbench

//  Sits between the branch FU (execute stage) and the BTB update port. Takes resolved branch outcomes
//  and checks each against the fetch-time prediction. On a mispredict it raises a one-cycle redirect

---
 rtl/branch_resolve_unit.sv | 155 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: checks resolved branches against their fetch-time prediction,
// raises a one-cycle redirect on mispredict, and queues taken branches for BTB training.
module branch_resolve_unit #(
  parameter int XLEN           = 32,
  parameter int QDEPTH         = 4,
  parameter bit DROP_NOT_TAKEN = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic                      ex_is_branch,
  input  logic [XLEN-1:0]           ex_PC,
  input  logic                      ex_taken,
  input  logic [XLEN-1:0]           ex_target_PC,
  input  logic                      ex_pred_taken,
  input  logic [XLEN-1:0]           ex_pred_target_PC,
  input  logic                      btb_stall,
  output logic                      mispredict,
  output logic [XLEN-1:0]           redirect_PC,
  output logic                      result_branch,
  output logic                      result_taken,
  output logic [XLEN-1:0]           result_PC,
  output logic [XLEN-1:0]           result_target_PC,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic [31:0]               branch_cnt,
  output logic [31:0]               mispred_cnt
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              mispredict_q, mispredict_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              res_branch_q, res_branch_d;
  logic              res_taken_q, res_taken_d;
  logic [XLEN-1:0]   res_pc_q, res_pc_d;
  logic [XLEN-1:0]   res_tgt_q, res_tgt_d;
  logic [31:0]       branch_cnt_q, branch_cnt_d;
  logic [31:0]       mispred_cnt_q, mispred_cnt_d;

  logic [XLEN-1:0]   pc_mem  [QDEPTH];
  logic [XLEN-1:0]   tgt_mem [QDEPTH];
  logic [QDEPTH-1:0] taken_mem;

  logic full;
  logic accept;
  logic mp;
  logic enq;
  logic deq;

  assign full   = (count_q == CW'(QDEPTH));
  assign accept = ex_valid & ~full & ex_is_branch;

  // A wrong target only matters when the branch actually went somewhere.
  assign mp  = (ex_taken != ex_pred_taken) |
               (ex_taken & (ex_pred_target_PC != ex_target_PC));
  assign enq = accept & (ex_taken | ~DROP_NOT_TAKEN);
  assign deq = (count_q != '0) & ~btb_stall;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    mispredict_d  = accept & mp;
    redirect_pc_d = redirect_pc_q;
    res_branch_d  = 1'b0;
    res_taken_d   = res_taken_q;
    res_pc_d      = res_pc_q;
    res_tgt_d     = res_tgt_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    if (accept && mp) begin
      redirect_pc_d = ex_taken ? ex_target_PC : (ex_PC + XLEN'(4));
    end

    if (enq) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (deq) begin
      rd_ptr_d     = rd_ptr_q + PW'(1);
      res_branch_d = 1'b1;
      res_taken_d  = taken_mem[rd_ptr_q];
      res_pc_d     = pc_mem[rd_ptr_q];
      res_tgt_d    = tgt_mem[rd_ptr_q];
    end

    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (accept && (branch_cnt_q != 32'hFFFF_FFFF)) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (accept && mp && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      res_branch_q  <= 1'b0;
      res_taken_q   <= 1'b0;
      res_pc_q      <= '0;
      res_tgt_q     <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
      res_branch_q  <= res_branch_d;
      res_taken_q   <= res_taken_d;
      res_pc_q      <= res_pc_d;
      res_tgt_q     <= res_tgt_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Storage needs no reset: occupancy and pointers alone decide what is valid.
  always_ff @(posedge clock) begin
    if (enq) begin
      pc_mem[wr_ptr_q]    <= ex_PC;
      tgt_mem[wr_ptr_q]   <= ex_target_PC;
      taken_mem[wr_ptr_q] <= ex_taken;
    end
  end

  assign ex_ready         = ~full;
  assign mispredict       = mispredict_q;
  assign redirect_PC      = redirect_pc_q;
  assign result_branch    = res_branch_q;
  assign result_taken     = res_taken_q;
  assign result_PC        = res_pc_q;
  assign result_target_PC = res_tgt_q;
  assign q_count          = count_q;
  assign branch_cnt       = branch_cnt_q;
  assign mispred_cnt      = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: prediction checks, redirect values,
// FIFO ordering under BTB stall, address wrap and asynchronous reset.
module tb_branch_resolve_unit;

  logic        clock;
  logic        reset_n;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_is_branch;
  logic [31:0] ex_PC;
  logic        ex_taken;
  logic [31:0] ex_target_PC;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target_PC;
  logic        btb_stall;
  logic        mispredict;
  logic [31:0] redirect_PC;
  logic        result_branch;
  logic        result_taken;
  logic [31:0] result_PC;
  logic [31:0] result_target_PC;
  logic [2:0]  q_count;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  branch_resolve_unit #(.XLEN(32), .QDEPTH(4), .DROP_NOT_TAKEN(1'b1)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .ex_valid          (ex_valid),
    .ex_ready          (ex_ready),
    .ex_is_branch      (ex_is_branch),
    .ex_PC             (ex_PC),
    .ex_taken          (ex_taken),
    .ex_target_PC      (ex_target_PC),
    .ex_pred_taken     (ex_pred_taken),
    .ex_pred_target_PC (ex_pred_target_PC),
    .btb_stall         (btb_stall),
    .mispredict        (mispredict),
    .redirect_PC       (redirect_PC),
    .result_branch     (result_branch),
    .result_taken      (result_taken),
    .result_PC         (result_PC),
    .result_target_PC  (result_target_PC),
    .q_count           (q_count),
    .branch_cnt        (branch_cnt),
    .mispred_cnt       (mispred_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                      input logic ptk, input logic [31:0] ptgt);
    ex_valid          = 1'b1;
    ex_is_branch      = 1'b1;
    ex_PC             = pc;
    ex_taken          = tk;
    ex_target_PC      = tgt;
    ex_pred_taken     = ptk;
    ex_pred_target_PC = ptgt;
  endtask

  task automatic idle();
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    btb_stall = 1'b0;
    ex_PC = '0; ex_taken = 0; ex_target_PC = '0; ex_pred_taken = 0; ex_pred_target_PC = '0;
    idle();
    #3;
    chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("rst_result_branch", {31'd0, result_branch}, 32'd0);
    chk("rst_q_count", {29'd0, q_count}, 32'd0);
    chk("rst_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_redirect", redirect_PC, 32'd0);
    chk("rst_branch_cnt", branch_cnt, 32'd0);
    #19 reset_n = 1'b1;
    step();

    // 1: correct taken prediction
    send(32'h100, 1, 32'h200, 1, 32'h200);
    step();
    chk("t1_mispredict", {31'd0, mispredict}, 32'd0);
    chk("t1_rb_t1", {31'd0, result_branch}, 32'd0);
    chk("t1_q_count", {29'd0, q_count}, 32'd1);
    chk("t1_branch_cnt", branch_cnt, 32'd1);
    idle();
    step();
    chk("t1_rb_t2", {31'd0, result_branch}, 32'd1);
    chk("t1_res_pc", result_PC, 32'h100);
    chk("t1_res_tgt", result_target_PC, 32'h200);
    chk("t1_res_taken", {31'd0, result_taken}, 32'd1);
    chk("t1_q_empty", {29'd0, q_count}, 32'd0);
    step();
    chk("t1_rb_pulse", {31'd0, result_branch}, 32'd0);
    chk("t1_res_pc_hold", result_PC, 32'h100);

    // 2: not taken but predicted taken
    send(32'h104, 0, 32'h500, 1, 32'h200);
    step();
    chk("t2_mispredict", {31'd0, mispredict}, 32'd1);
    chk("t2_redirect", redirect_PC, 32'h108);
    chk("t2_mispred_cnt", mispred_cnt, 32'd1);
    chk("t2_q_count", {29'd0, q_count}, 32'd0);
    idle();
    step();
    chk("t2_mp_pulse", {31'd0, mispredict}, 32'd0);
    chk("t2_no_update", {31'd0, result_branch}, 32'd0);
    chk("t2_redirect_hold", redirect_PC, 32'h108);

    // 3: taken, wrong target
    send(32'h110, 1, 32'h300, 1, 32'h200);
    step();
    chk("t3_mispredict", {31'd0, mispredict}, 32'd1);
    chk("t3_redirect", redirect_PC, 32'h300);
    chk("t3_mispred_cnt", mispred_cnt, 32'd2);
    chk("t3_q_count", {29'd0, q_count}, 32'd1);
    idle();
    step();
    chk("t3_rb", {31'd0, result_branch}, 32'd1);
    chk("t3_res_pc", result_PC, 32'h110);
    chk("t3_res_tgt", result_target_PC, 32'h300);
    step();

    // not taken, predicted not taken, targets differ: not a mispredict
    send(32'h120, 0, 32'h600, 0, 32'h700);
    step();
    chk("t3b_mispredict", {31'd0, mispredict}, 32'd0);
    chk("t3b_redirect_hold", redirect_PC, 32'h300);
    chk("t3b_q_count", {29'd0, q_count}, 32'd0);
    chk("t3b_branch_cnt", branch_cnt, 32'd4);
    idle();
    step();
    chk("t3b_no_update", {31'd0, result_branch}, 32'd0);

    // taken, predicted not taken
    send(32'h130, 1, 32'h140, 0, 32'h140);
    step();
    chk("t3c_mispredict", {31'd0, mispredict}, 32'd1);
    chk("t3c_redirect", redirect_PC, 32'h140);
    chk("t3c_mispred_cnt", mispred_cnt, 32'd3);
    idle();
    step();
    chk("t3c_res_pc", result_PC, 32'h130);
    step();

    // non-branch result is ignored
    send(32'h150, 1, 32'h900, 0, 32'h0);
    ex_is_branch = 1'b0;
    step();
    chk("nb_mispredict", {31'd0, mispredict}, 32'd0);
    chk("nb_branch_cnt", branch_cnt, 32'd5);
    chk("nb_q_count", {29'd0, q_count}, 32'd0);
    chk("nb_redirect", redirect_PC, 32'h140);
    idle();
    step();

    // 4: fill under stall, then drain in order
    btb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(32'h400 + 32'(4 * i), 1, 32'h800 + 32'(4 * i), 1, 32'h800 + 32'(4 * i));
      chk("t4_ready_fill", {31'd0, ex_ready}, 32'd1);
      step();
    end
    chk("t4_q_full", {29'd0, q_count}, 32'd4);
    chk("t4_rb_stalled", {31'd0, result_branch}, 32'd0);
    send(32'h410, 1, 32'h810, 1, 32'h810);
    chk("t4_ready_full", {31'd0, ex_ready}, 32'd0);
    step();
    chk("t4_q_hold", {29'd0, q_count}, 32'd4);
    chk("t4_branch_cnt_full", branch_cnt, 32'd9);
    btb_stall = 1'b0;
    step();
    chk("t4_rb0", {31'd0, result_branch}, 32'd1);
    chk("t4_pc0", result_PC, 32'h400);
    chk("t4_q0", {29'd0, q_count}, 32'd3);
    chk("t4_ready_again", {31'd0, ex_ready}, 32'd1);
    step();
    chk("t4_rb1", {31'd0, result_branch}, 32'd1);
    chk("t4_pc1", result_PC, 32'h404);
    chk("t4_q_enq_deq", {29'd0, q_count}, 32'd3);
    chk("t4_branch_cnt", branch_cnt, 32'd10);
    idle();
    for (int k = 2; k < 5; k++) begin
      step();
      chk("t4_rb_k", {31'd0, result_branch}, 32'd1);
      chk("t4_pc_k", result_PC, 32'h400 + 32'(4 * k));
      chk("t4_tgt_k", result_target_PC, 32'h800 + 32'(4 * k));
      chk("t4_q_k", {29'd0, q_count}, 32'(4 - k));
    end
    step();
    chk("t4_drained", {31'd0, result_branch}, 32'd0);

    // 5: PC+4 wraps
    send(32'hFFFF_FFFC, 0, 32'h0, 1, 32'h1000);
    step();
    chk("t5_mispredict", {31'd0, mispredict}, 32'd1);
    chk("t5_redirect_wrap", redirect_PC, 32'h0);
    chk("t5_mispred_cnt", mispred_cnt, 32'd4);
    idle();
    step();

    // 6: asynchronous reset with entries pending
    btb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(32'h600 + 32'(4 * i), 1, 32'hA00, 1, 32'hA00);
      step();
    end
    idle();
    btb_stall = 1'b0;
    step();
    chk("t6_rb_before", {31'd0, result_branch}, 32'd1);
    chk("t6_q_before", {29'd0, q_count}, 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rb_async", {31'd0, result_branch}, 32'd0);
    chk("t6_q_async", {29'd0, q_count}, 32'd0);
    chk("t6_branch_cnt", branch_cnt, 32'd0);
    chk("t6_mispred_cnt", mispred_cnt, 32'd0);
    chk("t6_redirect", redirect_PC, 32'd0);
    chk("t6_res_pc", result_PC, 32'd0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_no_update", {31'd0, result_branch}, 32'd0);
      chk("t6_q_zero", {29'd0, q_count}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
